regfile_scoreboard: RTL

Register file that feeds the pipeline's operand registers, with a per-register busy scoreboard for multi-cycle producers such as memory loads.
- Two combinational read ports feed the operand-latch stage directly downstream.
- One synchronous write port is driven by the write-back stage.
- Issue logic reserves a destination register; the matching write-back releases it.
- The stall logic reads the busy flags to hold dependent instructions.

---
 rtl/regfile_scoreboard_pkg.sv | 12 +
 rtl/regfile_busy_tracker.sv | 73 +++++++
 rtl/regfile_scoreboard.sv | 85 ++++++++
 3 files changed

// File: rtl/regfile_scoreboard_pkg.sv
// Shared definitions for the register file scoreboard and the stall logic
// that consumes its busy flags.
//   DEF_WIDTH / DEF_NREGS / DEF_AW : default geometry (8 x 8-bit, 3-bit addr)
//   REG_ZERO                       : index of the hardwired-zero register
package regfile_scoreboard_pkg;

    localparam int unsigned DEF_WIDTH = 8;
    localparam int unsigned DEF_NREGS = 8;
    localparam int unsigned DEF_AW    = 3;
    localparam int unsigned REG_ZERO  = 0;

endpackage

// File: rtl/regfile_busy_tracker.sv
// Busy scoreboard: one reservation bit per register, a running count of the
// set bits and a sticky double-reservation error flag.
// Ports:
//   clk, rst          : clock, asynchronous active-low reset
//   wr_en, wr_addr    : write-back strobe/address, releases a reservation
//   rsv_en, rsv_addr  : issue-side reservation strobe/address
//   busy_vec          : per-register busy bits (bit 0 always 0)
//   busy_count        : number of set busy bits
//   rsv_err           : sticky, reservation to an already-busy register
module regfile_busy_tracker
    import regfile_scoreboard_pkg::*;
#(
    parameter int unsigned NREGS = DEF_NREGS,
    parameter int unsigned AW    = DEF_AW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic             rsv_en,
    input  logic [AW-1:0]    rsv_addr,
    output logic [NREGS-1:0] busy_vec,
    output logic [AW:0]      busy_count,
    output logic             rsv_err
);

    logic [NREGS-1:0] busy_q, busy_d;
    logic [AW:0]      count_q, count_d;
    logic             err_q, err_d;

    logic wr_hit, rsv_hit, same_addr, claim_new, release_old;

    always_comb begin
        wr_hit    = wr_en  && (wr_addr  != AW'(REG_ZERO));
        rsv_hit   = rsv_en && (rsv_addr != AW'(REG_ZERO));
        same_addr = wr_hit && rsv_hit && (wr_addr == rsv_addr);

        // Count tracks transitions of the busy bits, so a same-address
        // write+reserve on a busy register is a release plus a new claim.
        claim_new   = rsv_hit && !busy_q[rsv_addr];
        release_old = wr_hit && busy_q[wr_addr] && !same_addr;

        // Reservation is applied after the write so it wins on collision.
        busy_d = busy_q;
        if (wr_hit)  busy_d[wr_addr]  = 1'b0;
        if (rsv_hit) busy_d[rsv_addr] = 1'b1;

        count_d = count_q;
        if (claim_new && !release_old)
            count_d = count_q + (AW+1)'(1);
        else if (release_old && !claim_new)
            count_d = count_q - (AW+1)'(1);

        err_d = err_q | (rsv_hit && busy_q[rsv_addr] && !same_addr);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_q  <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            busy_q  <= busy_d;
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    assign busy_vec   = busy_q;
    assign busy_count = count_q;
    assign rsv_err    = err_q;

endmodule

// File: rtl/regfile_scoreboard.sv
// Register file with two combinational read ports, one synchronous write
// port and a per-register busy scoreboard. Register 0 reads as zero and is
// never written or reserved.
// Optional: define REGFILE_WRITE_BYPASS_EN to forward same-cycle write data
// (and the busy release) onto the read ports.
// Ports:
//   clk, rst                         : clock, asynchronous active-low reset
//   rd_addr_a/rd_data_a/busy_a       : read port A
//   rd_addr_b/rd_data_b/busy_b       : read port B
//   wr_en, wr_addr, wr_data          : write-back port
//   rsv_en, rsv_addr                 : reservation port
//   busy_count, rsv_err              : scoreboard status
module regfile_scoreboard
    import regfile_scoreboard_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned NREGS = DEF_NREGS,
    parameter int unsigned AW    = DEF_AW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [AW-1:0]    rd_addr_a,
    output logic [WIDTH-1:0] rd_data_a,
    output logic             busy_a,
    input  logic [AW-1:0]    rd_addr_b,
    output logic [WIDTH-1:0] rd_data_b,
    output logic             busy_b,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rsv_en,
    input  logic [AW-1:0]    rsv_addr,
    output logic [AW:0]      busy_count,
    output logic             rsv_err
);

    logic [WIDTH-1:0] regs_q [NREGS];
    logic [NREGS-1:0] busy_vec;
    logic             wr_hit;

    assign wr_hit = wr_en && (wr_addr != AW'(REG_ZERO));

    regfile_busy_tracker #(
        .NREGS (NREGS),
        .AW    (AW)
    ) u_busy (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .rsv_en     (rsv_en),
        .rsv_addr   (rsv_addr),
        .busy_vec   (busy_vec),
        .busy_count (busy_count),
        .rsv_err    (rsv_err)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < NREGS; i++)
                regs_q[i] <= '0;
        end else if (wr_hit) begin
            regs_q[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        rd_data_a = (rd_addr_a == AW'(REG_ZERO)) ? '0 : regs_q[rd_addr_a];
        busy_a    = busy_vec[rd_addr_a];
        rd_data_b = (rd_addr_b == AW'(REG_ZERO)) ? '0 : regs_q[rd_addr_b];
        busy_b    = busy_vec[rd_addr_b];
`ifdef REGFILE_WRITE_BYPASS_EN
        // Forward the in-flight write; a same-address reservation keeps it busy.
        if (wr_hit && (rd_addr_a == wr_addr)) begin
            rd_data_a = wr_data;
            busy_a    = rsv_en && (rsv_addr == wr_addr);
        end
        if (wr_hit && (rd_addr_b == wr_addr)) begin
            rd_data_b = wr_data;
            busy_b    = rsv_en && (rsv_addr == wr_addr);
        end
`endif
    end

endmodule
